// File: rtl/bitsixtyfour_array_seq_if.sv
// -----------------------------------------------------------------------------
// bitsixtyfour_array_seq_if
//
// Purpose:
//   Bundles every non-clock signal of the 64-bit array sequencer into one
//   interface. It carries three groups of signals:
//     - the request channel, which also carries the settle configuration,
//     - the analog array drive/sense buses,
//     - the response channel.
//
// Modports:
//   slave  - the sequencer side (bitsixtyfour_array_seq).
//   master - the requester side (the host logic, or a testbench).
//
// Signal summary:
//   cfg_settle [SETTLE_W]      settle cycles; 0 is treated as 1.
//   req_valid / req_ready      request handshake.
//   req_x, req_k [BIT_SIZE]    operands.
//   arr_x, arr_x_bar,
//   arr_k, arr_k_bar [BIT_SIZE] true/complement rails to the array.
//   arr_s [BIT_SIZE]           array output; asynchronous to the clock.
//   rsp_valid / rsp_ready      response handshake.
//   rsp_s [BIT_SIZE]           captured array word.
//   rsp_pop [POP_W]            number of ones in rsp_s.
//   busy                       sequencer is not idle.
// -----------------------------------------------------------------------------
interface bitsixtyfour_array_seq_if #(
   parameter int BIT_SIZE = 64,
   parameter int SETTLE_W = 8,
   parameter int POP_W    = 7
);

   logic [SETTLE_W-1:0] cfg_settle;
   logic                req_valid;
   logic                req_ready;
   logic [BIT_SIZE-1:0] req_x;
   logic [BIT_SIZE-1:0] req_k;
   logic [BIT_SIZE-1:0] arr_x;
   logic [BIT_SIZE-1:0] arr_x_bar;
   logic [BIT_SIZE-1:0] arr_k;
   logic [BIT_SIZE-1:0] arr_k_bar;
   logic [BIT_SIZE-1:0] arr_s;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [BIT_SIZE-1:0] rsp_s;
   logic [POP_W-1:0]    rsp_pop;
   logic                busy;

   // The sequencer consumes requests and array sense data, and produces
   // array drive, responses and status.
   modport slave (
      input  cfg_settle, req_valid, req_x, req_k, arr_s, rsp_ready,
      output req_ready, arr_x, arr_x_bar, arr_k, arr_k_bar,
             rsp_valid, rsp_s, rsp_pop, busy
   );

   // The requester mirrors the sequencer view.
   modport master (
      output cfg_settle, req_valid, req_x, req_k, arr_s, rsp_ready,
      input  req_ready, arr_x, arr_x_bar, arr_k, arr_k_bar,
             rsp_valid, rsp_s, rsp_pop, busy
   );

endinterface

// File: rtl/bitsixtyfour_array_seq.sv
// -----------------------------------------------------------------------------
// bitsixtyfour_array_seq
//
// Purpose:
//   Sequencer for the 64-bit complementary-input analog CMOS array.
//   One request is handled at a time:
//     - the operand pair is latched when the request is accepted,
//     - the true and complement rails are driven for a programmable number
//       of settle cycles,
//     - the asynchronous s outputs are sampled through a 2-flop synchronizer,
//     - the captured word and its population count are returned on a
//       valid/ready response channel.
//
// Ports:
//   wb_clk_i - single clock.
//   wb_rst_i - asynchronous, active-high reset.
//   bus      - bitsixtyfour_array_seq_if.slave; carries the request,
//              array and response signals.
//
// Configuration:
//   BITSIXTYFOUR_SAMPLE_VOTE_EN
//     Undefined (default): SAMPLE lasts 2 cycles and the synchronizer
//       output is captured once, on the last SAMPLE edge.
//     Defined: SAMPLE lasts 5 cycles. The synchronizer output is captured
//       on SAMPLE cycles 3, 4 and 5. The response carries the bitwise
//       majority of the three captures.
// -----------------------------------------------------------------------------
module bitsixtyfour_array_seq #(
   parameter int BIT_SIZE = 64,
   parameter int SETTLE_W = 8,
   parameter int POP_W    = 7
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   bitsixtyfour_array_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      RESP   = 2'd3
   } state_t;

   // SAMPLE sub-counter value on the final SAMPLE edge. SAMPLE lasts
   // (SAMPLE_LAST + 1) cycles.
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
   localparam logic [2:0] SAMPLE_LAST = 3'd4;
`else
   localparam logic [2:0] SAMPLE_LAST = 3'd1;
`endif

   state_t              state_q, state_d;
   logic [BIT_SIZE-1:0] xReg_q, xReg_d;
   logic [BIT_SIZE-1:0] kReg_q, kReg_d;
   logic [SETTLE_W-1:0] settleCnt_q, settleCnt_d;
   logic [2:0]          subCnt_q, subCnt_d;
   logic [BIT_SIZE-1:0] sync1_q, sync2_q;
   logic [BIT_SIZE-1:0] arrX_q, arrX_d;
   logic [BIT_SIZE-1:0] arrXBar_q, arrXBar_d;
   logic [BIT_SIZE-1:0] arrK_q, arrK_d;
   logic [BIT_SIZE-1:0] arrKBar_q, arrKBar_d;
   logic                rspValid_q, rspValid_d;
   logic [BIT_SIZE-1:0] rspS_q, rspS_d;
   logic [POP_W-1:0]    rspPop_q, rspPop_d;
   logic [BIT_SIZE-1:0] capturedWord;
   logic                driveOn;
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
   logic [BIT_SIZE-1:0] voteA_q, voteA_d;
   logic [BIT_SIZE-1:0] voteB_q, voteB_d;
`endif

   // Counts the ones in a word.
   // The width of the sum covers the full range 0..BIT_SIZE.
   function automatic logic [POP_W-1:0] popCount(input logic [BIT_SIZE-1:0] w);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < BIT_SIZE; i++) begin
         n = n + POP_W'(w[i]);
      end
      return n;
   endfunction

   // Two-flop synchronizer on the array outputs.
   // arr_s changes with no relation to wb_clk_i, so nothing downstream ever
   // looks at it directly. The synchronizer runs every cycle, whatever the
   // FSM state, so it is already primed when SAMPLE starts.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.arr_s;
         sync2_q <= sync1_q;
      end
   end

   // State and datapath registers.
   // The array drive registers sit here too, so the rails come straight off
   // flops. An asynchronous reset therefore neutralises the array at once,
   // without waiting for a clock edge.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         xReg_q      <= '0;
         kReg_q      <= '0;
         settleCnt_q <= '0;
         subCnt_q    <= '0;
         arrX_q      <= '0;
         arrXBar_q   <= '0;
         arrK_q      <= '0;
         arrKBar_q   <= '0;
         rspValid_q  <= 1'b0;
         rspS_q      <= '0;
         rspPop_q    <= '0;
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
         voteA_q     <= '0;
         voteB_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         xReg_q      <= xReg_d;
         kReg_q      <= kReg_d;
         settleCnt_q <= settleCnt_d;
         subCnt_q    <= subCnt_d;
         arrX_q      <= arrX_d;
         arrXBar_q   <= arrXBar_d;
         arrK_q      <= arrK_d;
         arrKBar_q   <= arrKBar_d;
         rspValid_q  <= rspValid_d;
         rspS_q      <= rspS_d;
         rspPop_q    <= rspPop_d;
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
         voteA_q     <= voteA_d;
         voteB_q     <= voteB_d;
`endif
      end
   end

   // Word handed to the response on the final SAMPLE edge.
   // With voting, two earlier captures are combined with the live
   // synchronizer output, so a single-cycle upset on one bit is outvoted.
   always_comb begin
      capturedWord = sync2_q;
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
      capturedWord = (voteA_q & voteB_q) | (voteA_q & sync2_q) | (voteB_q & sync2_q);
`endif
   end

   // Next-state and datapath logic for the four-state sequence
   // IDLE -> DRIVE -> SAMPLE -> RESP.
   // The settle count is sampled once, at accept, so later changes on
   // cfg_settle cannot disturb an operation in flight. A zero setting is
   // promoted to one, so DRIVE always lasts at least a cycle.
   always_comb begin
      state_d     = state_q;
      xReg_d      = xReg_q;
      kReg_d      = kReg_q;
      settleCnt_d = settleCnt_q;
      subCnt_d    = subCnt_q;
      rspValid_d  = rspValid_q;
      rspS_d      = rspS_q;
      rspPop_d    = rspPop_q;
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
      voteA_d     = voteA_q;
      voteB_d     = voteB_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               xReg_d      = bus.req_x;
               kReg_d      = bus.req_k;
               settleCnt_d = (bus.cfg_settle == '0) ? SETTLE_W'(1) : bus.cfg_settle;
               state_d     = DRIVE;
            end
         end

         DRIVE: begin
            if (settleCnt_q == SETTLE_W'(1)) begin
               subCnt_d = '0;
               state_d  = SAMPLE;
            end else begin
               settleCnt_d = settleCnt_q - SETTLE_W'(1);
            end
         end

         SAMPLE: begin
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
            if (subCnt_q == 3'd2) begin
               voteA_d = sync2_q;
            end
            if (subCnt_q == 3'd3) begin
               voteB_d = sync2_q;
            end
`endif
            if (subCnt_q == SAMPLE_LAST) begin
               rspS_d     = capturedWord;
               rspPop_d   = popCount(capturedWord);
               rspValid_d = 1'b1;
               state_d    = RESP;
            end else begin
               subCnt_d = subCnt_q + 3'd1;
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               rspValid_d = 1'b0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Array drive for the coming cycle.
   // The drive is derived from the next state, so the registered rails are
   // live throughout DRIVE and SAMPLE and are zero throughout IDLE and RESP.
   // In the zero state both rails of a bit are low, so true and complement
   // are never high together.
   always_comb begin
      driveOn   = (state_d == DRIVE) || (state_d == SAMPLE);
      arrX_d    = '0;
      arrXBar_d = '0;
      arrK_d    = '0;
      arrKBar_d = '0;
      if (driveOn) begin
         arrX_d    = xReg_d;
         arrXBar_d = ~xReg_d;
         arrK_d    = kReg_d;
         arrKBar_d = ~kReg_d;
      end
   end

   // Status and outputs.
   // busy and req_ready decode the state register directly, so both change
   // immediately when reset is asserted.
   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.arr_x     = arrX_q;
   assign bus.arr_x_bar = arrXBar_q;
   assign bus.arr_k     = arrK_q;
   assign bus.arr_k_bar = arrKBar_q;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_s     = rspS_q;
   assign bus.rsp_pop   = rspPop_q;

endmodule

// File: tb/tb_bitsixtyfour_array_seq.sv
// -----------------------------------------------------------------------------
// tb_bitsixtyfour_array_seq
//
// Purpose:
//   Self-checking bench for bitsixtyfour_array_seq.
//   The analog array is modelled as s = x ^ k, registered once, so it has
//   one cycle of delay.
//   Directed vectors come from a table. Hand-written sequences then cover:
//     - backpressure,
//     - reset in the middle of DRIVE,
//     - the vote corner, when BITSIXTYFOUR_SAMPLE_VOTE_EN is defined.
// -----------------------------------------------------------------------------
module tb_bitsixtyfour_array_seq;

   localparam int BIT_SIZE = 64;
   localparam int SETTLE_W = 8;
   localparam int POP_W    = 7;
`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
   localparam int SAMPLE_CYC = 5;
`else
   localparam int SAMPLE_CYC = 2;
`endif

   typedef struct {
      logic [SETTLE_W-1:0] settle;
      logic [BIT_SIZE-1:0] x;
      logic [BIT_SIZE-1:0] k;
      logic [BIT_SIZE-1:0] expS;
      logic [POP_W-1:0]    expPop;
      logic                chkData;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [BIT_SIZE-1:0] arrModel = '0;
   logic [BIT_SIZE-1:0] glitch   = '0;
   int vecCount  = 0;
   int missCount = 0;
   vec_t vecs[7];

   bitsixtyfour_array_seq_if #(
      .BIT_SIZE(BIT_SIZE), .SETTLE_W(SETTLE_W), .POP_W(POP_W)
   ) bus ();

   bitsixtyfour_array_seq #(
      .BIT_SIZE(BIT_SIZE), .SETTLE_W(SETTLE_W), .POP_W(POP_W)
   ) dut (
      .wb_clk_i (clock),
      .wb_rst_i (reset),
      .bus      (bus)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Array model: the s outputs follow x ^ k one cycle later.
   // glitch lets a sequence upset individual bits for a single cycle.
   always @(posedge clock) begin
      arrModel <= (bus.arr_x ^ bus.arr_k) ^ glitch;
   end
   assign bus.arr_s = arrModel;

   // Watchdog, so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Makes one comparison and reports it if it does not match.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Presents a request at the falling edge and waits for the accepting
   // rising edge. After the accept, cfg_settle is moved to a different
   // value, so an operation that re-read it would show the wrong latency.
   task automatic startRequest(input logic [SETTLE_W-1:0] settle,
                               input logic [BIT_SIZE-1:0] x,
                               input logic [BIT_SIZE-1:0] k);
      @(negedge clock);
      bus.cfg_settle = settle;
      bus.req_x      = x;
      bus.req_k      = k;
      bus.req_valid  = 1'b1;
      @(posedge clock);
      #1;
      bus.req_valid  = 1'b0;
      bus.cfg_settle = settle + 8'd37;
   endtask

   // Counts rising edges after the accept until rsp_valid is seen.
   // The wait is bounded; if the bound expires, the latency check fails.
   task automatic waitResponse(input int expLat, input int startEdges, input string name);
      int edges;
      edges = startEdges;
      while (bus.rsp_valid !== 1'b1 && edges < 600) begin
         @(posedge clock);
         #1;
         edges++;
      end
      checkOutput({name, " latency"}, 64'(edges), 64'(expLat));
   endtask

   // Completes the response handshake and checks the return to IDLE.
   task automatic handshake(input string name);
      @(negedge clock);
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.rsp_ready = 1'b0;
      checkOutput({name, " rsp_valid after handshake"}, 64'(bus.rsp_valid), 64'd0);
      checkOutput({name, " req_ready after handshake"}, 64'(bus.req_ready), 64'd1);
   endtask

   // Runs one table vector from start to finish.
   // Latency is always checked. Data is checked only when the settle time
   // is long enough for the array model's delay plus the synchronizer.
   task automatic applyStimulus(input vec_t v, input string name);
      int n;
      n = (v.settle == '0) ? 1 : int'(v.settle);
      checkOutput({name, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
      startRequest(v.settle, v.x, v.k);
      checkOutput({name, " busy in DRIVE"}, 64'(bus.busy), 64'd1);
      checkOutput({name, " arr_x_bar in DRIVE"}, bus.arr_x_bar, ~v.x);
      checkOutput({name, " arr_k_bar in DRIVE"}, bus.arr_k_bar, ~v.k);
      waitResponse(n + SAMPLE_CYC, 0, name);
      checkOutput({name, " arr_x in RESP"}, bus.arr_x, 64'd0);
      if (v.chkData) begin
         checkOutput({name, " rsp_s"}, bus.rsp_s, v.expS);
         checkOutput({name, " rsp_pop"}, 64'(bus.rsp_pop), 64'(v.expPop));
      end
      handshake(name);
      if (v.chkData) begin
         checkOutput({name, " rsp_s held"}, bus.rsp_s, v.expS);
      end
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.rsp_ready  = 1'b0;
      bus.cfg_settle = '0;
      bus.req_x      = '0;
      bus.req_k      = '0;

      // Hand-computed vectors: settle, x, k, expected s, expected popcount,
      // and whether the data is checked.
      vecs[0] = '{8'd4, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F,
                  64'hF0F00F0FF0F00F0F, 7'd32, 1'b1};
      vecs[1] = '{8'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
                  64'h0, 7'd0, 1'b0};
      vecs[2] = '{8'd4, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                  64'h0000000000000000, 7'd0, 1'b1};
      vecs[3] = '{8'd4, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
                  64'hFFFFFFFFFFFFFFFF, 7'd64, 1'b1};
      vecs[4] = '{8'd2, 64'h0123456789ABCDEF, 64'h0000000000000000,
                  64'h0123456789ABCDEF, 7'd32, 1'b1};
      vecs[5] = '{8'd7, 64'h8000000000000001, 64'h0000000000000001,
                  64'h8000000000000000, 7'd1, 1'b1};
      vecs[6] = '{8'd1, 64'h00000000000000FF, 64'h0,
                  64'h0, 7'd0, 1'b0};

      // Reset state, checked while reset is held.
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset req_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("reset arr_x", bus.arr_x, 64'd0);
      checkOutput("reset arr_x_bar", bus.arr_x_bar, 64'd0);
      checkOutput("reset arr_k_bar", bus.arr_k_bar, 64'd0);
      checkOutput("reset rsp_s", bus.rsp_s, 64'd0);
      checkOutput("reset rsp_pop", 64'(bus.rsp_pop), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure.
      // The response is held for 10 cycles while a second request waits.
      // The waiting request must be accepted on the edge after the handshake.
      $display("[TB] backpressure sequence");
      startRequest(8'd3, 64'hAAAAAAAAAAAAAAAA, 64'h0);
      waitResponse(3 + SAMPLE_CYC, 0, "bp first");
      @(negedge clock);
      bus.cfg_settle = 8'd5;
      bus.req_x      = 64'hFFFFFFFFFFFFFFFF;
      bus.req_k      = 64'h0;
      bus.req_valid  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock);
         #1;
         checkOutput("bp rsp_valid", 64'(bus.rsp_valid), 64'd1);
         checkOutput("bp rsp_s", bus.rsp_s, 64'hAAAAAAAAAAAAAAAA);
         checkOutput("bp rsp_pop", 64'(bus.rsp_pop), 64'd32);
         checkOutput("bp req_ready", 64'(bus.req_ready), 64'd0);
         checkOutput("bp arr_all", bus.arr_x | bus.arr_x_bar | bus.arr_k | bus.arr_k_bar, 64'd0);
      end
      @(negedge clock);
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.rsp_ready = 1'b0;
      checkOutput("bp rsp_valid after handshake", 64'(bus.rsp_valid), 64'd0);
      checkOutput("bp busy after handshake", 64'(bus.busy), 64'd0);
      @(posedge clock);
      #1;
      bus.req_valid  = 1'b0;
      bus.cfg_settle = 8'd99;
      checkOutput("bp second accepted", 64'(bus.busy), 64'd1);
      waitResponse(5 + SAMPLE_CYC, 0, "bp second");
      checkOutput("bp second rsp_s", bus.rsp_s, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("bp second rsp_pop", 64'(bus.rsp_pop), 64'd64);
      handshake("bp second");

      // Reset in the middle of DRIVE.
      // Outputs must clear without waiting for a clock edge.
      $display("[TB] reset mid-DRIVE sequence");
      startRequest(8'd20, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321);
      repeat (4) @(posedge clock);
      #1;
      checkOutput("rst pre busy", 64'(bus.busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst busy", 64'(bus.busy), 64'd0);
      checkOutput("rst arr_x", bus.arr_x, 64'd0);
      checkOutput("rst arr_x_bar", bus.arr_x_bar, 64'd0);
      checkOutput("rst arr_k", bus.arr_k, 64'd0);
      checkOutput("rst arr_k_bar", bus.arr_k_bar, 64'd0);
      checkOutput("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("rst release req_ready", 64'(bus.req_ready), 64'd1);
      applyStimulus(vecs[0], "post-reset");

`ifdef BITSIXTYFOUR_SAMPLE_VOTE_EN
      // Vote.
      // Bit 7 of arr_s is flipped for exactly one cycle, timed to reach the
      // final capture only. The majority must reject it.
      $display("[TB] vote sequence");
      startRequest(8'd4, 64'h0, 64'h0);
      repeat (5) @(posedge clock);
      @(negedge clock);
      glitch = 64'h80;
      @(posedge clock);
      #1;
      glitch = '0;
      waitResponse(4 + 5, 4 + 2, "vote");
      checkOutput("vote rsp_s", bus.rsp_s, 64'd0);
      checkOutput("vote rsp_pop", 64'(bus.rsp_pop), 64'd0);
      handshake("vote");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/bitsixtyfour_array_seq.md
Name: bitsixtyfour_array_seq

Overview:
- Sequencer for the 64-bit complementary-input analog CMOS array (x/x_bar/k/k_bar in, s out).
- Accepts one operand pair per request and drives the true and complement rails.
- Waits a programmable settle time, then samples the asynchronous s outputs through a synchronizer.
- Returns the captured word plus a population count over a valid/ready response channel.

Parameters:
BIT_SIZE, 64, array width; must match the array instance.
SETTLE_W, 8, width of the settle-cycle configuration input.
POP_W, 7, popcount width; equals clog2(BIT_SIZE+1).

Ports:
wb_clk_i  input  1  single clock.
wb_rst_i  input  1  reset, asynchronous, active-high.
cfg_settle  input  SETTLE_W  settle cycles; 0 is treated as 1; sampled at request accept.
req_valid  input  1  request valid.
req_ready  output  1  request ready; high only in IDLE.
req_x  input  BIT_SIZE  operand x.
req_k  input  BIT_SIZE  operand k.
arr_x  output  BIT_SIZE  to array x.
arr_x_bar  output  BIT_SIZE  to array x_bar.
arr_k  output  BIT_SIZE  to array k.
arr_k_bar  output  BIT_SIZE  to array k_bar.
arr_s  input  BIT_SIZE  array s; asynchronous to wb_clk_i.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response ready.
rsp_s  output  BIT_SIZE  captured s word.
rsp_pop  output  POP_W  number of ones in rsp_s.
busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: state IDLE; all arr_* = 0; rsp_valid = 0; rsp_s = 0; rsp_pop = 0; settle counter = 0; synchronizer flops = 0.
- Reset takes effect immediately at any point, including mid-operation.
- arr_s passes continuously through a 2-flop synchronizer. Only the synchronizer output is ever used.
- Array drive:
  - In DRIVE and SAMPLE: arr_x = x_reg, arr_x_bar = ~x_reg, arr_k = k_reg, arr_k_bar = ~k_reg, all from registered outputs.
  - In IDLE and RESP: all four buses = 0 (neutral/discharge). True and complement are never both 1 on a bit.
- IDLE:
  - req_ready = 1.
  - On req_valid at a rising edge: latch req_x, req_k; load cnt = max(cfg_settle, 1); go to DRIVE.
- DRIVE:
  - Each edge: if cnt == 1, go to SAMPLE and clear the sub-counter; else cnt = cnt - 1.
  - Occupies exactly max(cfg_settle, 1) cycles.
- SAMPLE:
  - Lasts 2 cycles to flush the synchronizer; drives are held.
  - On the final edge: rsp_s = sync output, rsp_pop = popcount(sync output), rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_s and rsp_pop are held stable until the handshake.
  - On rsp_valid && rsp_ready: rsp_valid = 0, go to IDLE. rsp_s and rsp_pop keep their last values.
- Latency:
  - Request accepted at edge E0 gives rsp_valid high after edge E0 + N + 2, where N = max(cfg_settle, 1).
  - Earliest next accept is the edge after the response handshake (no overlap).
- Other rules:
  - cfg_settle changes after accept have no effect on the operation in flight.
  - req_valid outside IDLE is ignored; the requester must hold it.
  - Popcount range is 0..64 and fits POP_W without overflow.

Optional Feature:
BITSIXTYFOUR_SAMPLE_VOTE_EN
- Defined:
  - SAMPLE lasts 5 cycles.
  - Synchronizer output is captured on cycles 3, 4 and 5.
  - rsp_s = bitwise majority of the three captures; rsp_pop is computed on the voted word.
  - Latency becomes N + 5 edges.
- Undefined: 2-cycle single capture as described above. No vote logic is instantiated.

Test Plan:
- Bench array model is s = x ^ k with 1-cycle delay.
- Basic: cfg_settle = 4, x = 0xFFFF0000FFFF0000, k = 0x0F0F0F0F0F0F0F0F -> arr_x_bar = 0x0000FFFF0000FFFF during DRIVE; rsp_valid high 6 edges after accept; rsp_s = 0xF0F00F0FF0F00F0F; rsp_pop = 32.
- Settle 0: cfg_settle = 0 -> DRIVE lasts 1 cycle; rsp_valid 3 edges after accept.
- Extremes:
  - x = k = all ones -> rsp_pop = 0.
  - x = all ones, k = 0 -> rsp_s = all ones, rsp_pop = 64.
- Backpressure: rsp_ready low for 10 cycles -> rsp_valid, rsp_s, rsp_pop stable; req_ready = 0; all arr_* = 0; with a second req_valid held, it is accepted the edge after the rsp handshake.
- Reset mid-DRIVE (cfg_settle = 20, wb_rst_i asserted on cycle 5) -> arr_*, rsp_valid, busy go to 0 without waiting for a clock edge; after release, req_ready = 1 and a new request completes normally.
- Vote (macro defined): arr_s bit 7 forced to 1 for exactly one capture cycle while the model produces 0 -> rsp_s bit 7 = 0; latency N + 5.
